sw_debounce: RTL and testbench

- Conditions a raw mechanical switch/pushbutton input before it reaches the top-level `sw` toggle logic.
- Synchronises the asynchronous pin and debounces it against a tick strobe from a `clock_enable` instance.
- Outputs a clean level plus single-cycle rise/fall pulses; downstream logic consumes `o_rise` as its `sw` input.

---
 rtl/sw_debounce.sv | 163 ++++++++++++++++
 tb/tb_sw_debounce.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// sw_debounce: synchronises a raw switch pin and debounces it against a tick
// strobe. It produces a clean level, one-clk rise/fall pulses and a busy
// flag. The busy flag is high while a candidate edge is being qualified.
// Optional long-press detector: define SW_DEBOUNCE_LONGPRESS_EN to build it.
// Without the macro, o_long is tied low.
module sw_debounce #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int LONG_TICKS     = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_sw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_busy,
    output logic o_long
);

    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W:0] DB_LAST = (CNT_W + 1)'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sw_s;

    // Parameter legality is checked once, at elaboration.
    if (DEBOUNCE_TICKS < 1 || SYNC_STAGES < 2 || LONG_TICKS < 1) begin : g_bad_param
        $error("sw_debounce: DEBOUNCE_TICKS>=1, SYNC_STAGES>=2, LONG_TICKS>=1 required");
    end

    // Saturating increment: the qualification counter never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if ({1'b0, v} >= DB_LAST)
            return v;
        return v + CNT_W'(1);
    endfunction

    // True when this tick is the last one needed to accept the new level.
    function automatic logic is_last_tick(input logic [CNT_W-1:0] v);
        return ({1'b0, v} + (CNT_W + 1)'(1)) == DB_LAST;
    endfunction

    assign sw_s = sync_q[SYNC_STAGES-1];

    // Shift the raw pin through the synchroniser chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sync_q <= '0;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_sw};
    end

    // Debounce FSM with registered level, pulse and busy outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE_LOW;
            cnt     <= '0;
            o_level <= 1'b0;
            o_rise  <= 1'b0;
            o_fall  <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            o_rise <= 1'b0;
            o_fall <= 1'b0;
            case (state)
                IDLE_LOW: begin
                    if (sw_s) begin
                        state  <= WAIT_HIGH;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    // A bounce takes priority over a coincident tick.
                    if (!sw_s) begin
                        state  <= IDLE_LOW;
                        cnt    <= '0;
                        o_busy <= 1'b0;
                    end else if (i_tick) begin
                        if (is_last_tick(cnt)) begin
                            state   <= IDLE_HIGH;
                            cnt     <= '0;
                            o_level <= 1'b1;
                            o_rise  <= 1'b1;
                            o_busy  <= 1'b0;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end
                end
                IDLE_HIGH: begin
                    if (!sw_s) begin
                        state  <= WAIT_LOW;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                    end
                end
                WAIT_LOW: begin
                    if (sw_s) begin
                        state  <= IDLE_HIGH;
                        cnt    <= '0;
                        o_busy <= 1'b0;
                    end else if (i_tick) begin
                        if (is_last_tick(cnt)) begin
                            state   <= IDLE_LOW;
                            cnt     <= '0;
                            o_level <= 1'b0;
                            o_fall  <= 1'b1;
                            o_busy  <= 1'b0;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end
                end
                default: begin
                    state   <= IDLE_LOW;
                    cnt     <= '0;
                    o_level <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SW_DEBOUNCE_LONGPRESS_EN
    localparam int LONG_W = $clog2(LONG_TICKS + 1);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_TICKS);

    logic [LONG_W-1:0] long_cnt;

    // Count ticks while the level is steadily high. Fire once at LONG_TICKS.
    // Clear the count as soon as IDLE_HIGH is being left.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            long_cnt <= '0;
            o_long   <= 1'b0;
        end else begin
            o_long <= 1'b0;
            if (state != IDLE_HIGH || !sw_s) begin
                long_cnt <= '0;
            end else if (i_tick && long_cnt != LONG_MAX) begin
                long_cnt <= long_cnt + LONG_W'(1);
                if (long_cnt + LONG_W'(1) == LONG_MAX)
                    o_long <= 1'b1;
            end
        end
    end
`else
    assign o_long = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Testbench for sw_debounce: directed scenarios plus randomized switch
// activity, checked cycle by cycle against a streak/tick-count reference.
module tb_sw_debounce;

    localparam int SYNC = 2;
    localparam int DT   = 4;
    localparam int LONG = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_tick = 1'b0;
    logic i_sw = 1'b0;
    logic o_level, o_rise, o_fall, o_busy, o_long;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic m_level, m_pending, m_rise, m_fall, m_long;
    int   m_ticks, m_lcnt;
    logic hist[$];

    // observation counters for directed checks
    int cyc;
    int rise_seen, fall_seen, long_seen, busy_seen;
    int last_rise_cyc, last_long_cyc, first_rise_cyc;

    sw_debounce #(
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_TICKS(DT),
        .LONG_TICKS(LONG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_tick(i_tick),
        .i_sw(i_sw),
        .o_level(o_level),
        .o_rise(o_rise),
        .o_fall(o_fall),
        .o_busy(o_busy),
        .o_long(o_long)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_level = 1'b0; m_pending = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
        m_long = 1'b0; m_ticks = 0; m_lcnt = 0;
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
    endtask

    // One clock edge of the reference: the switch value the debouncer sees is
    // the pin as it was SYNC edges ago; the level flips once a streak of
    // disagreeing samples has accumulated DT ticks (first streak edge excluded).
    task automatic model_edge(input logic sw, input logic tick);
        logic s;
        if (!rst) begin
            model_reset();
            return;
        end
        s = hist.pop_front();
        hist.push_back(sw);
        m_rise = 1'b0; m_fall = 1'b0; m_long = 1'b0;
`ifdef SW_DEBOUNCE_LONGPRESS_EN
        if (m_level && !m_pending && s) begin
            if (tick && m_lcnt < LONG) begin
                m_lcnt++;
                if (m_lcnt == LONG) m_long = 1'b1;
            end
        end else begin
            m_lcnt = 0;
        end
`endif
        if (s == m_level) begin
            m_pending = 1'b0; m_ticks = 0;
        end else if (!m_pending) begin
            m_pending = 1'b1; m_ticks = 0;
        end else if (tick) begin
            m_ticks++;
            if (m_ticks == DT) begin
                m_level = s; m_rise = s; m_fall = ~s;
                m_pending = 1'b0; m_ticks = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".level"}, o_level, m_level);
        check({tag, ".rise"},  o_rise,  m_rise);
        check({tag, ".fall"},  o_fall,  m_fall);
        check({tag, ".busy"},  o_busy,  m_pending);
        check({tag, ".long"},  o_long,  m_long);
    endtask

    task automatic clear_obs();
        cyc = 0; rise_seen = 0; fall_seen = 0; long_seen = 0; busy_seen = 0;
        last_rise_cyc = -1; last_long_cyc = -1; first_rise_cyc = -1;
    endtask

    // Drive inputs away from the edge, advance one clk, then compare.
    task automatic cycle(input string tag, input logic sw, input logic tick);
        i_sw = sw; i_tick = tick;
        @(posedge clk);
        model_edge(sw, tick);
        #1;
        cyc++;
        if (o_rise) begin
            rise_seen++; last_rise_cyc = cyc;
            if (first_rise_cyc < 0) first_rise_cyc = cyc;
        end
        if (o_fall) fall_seen++;
        if (o_long) begin long_seen++; last_long_cyc = cyc; end
        if (o_busy) busy_seen++;
        check_all(tag);
    endtask

    // Assert reset asynchronously between edges; outputs must clear at once.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all({tag, ".async"});
        cycle(tag, i_sw, i_tick);
        cycle(tag, i_sw, i_tick);
        rst = 1'b1;
    endtask

    initial begin
        logic v;
        int len, tp;
        model_reset();
        clear_obs();

        // Reset with the pin already high.
        i_sw = 1'b1; i_tick = 1'b1;
        #1 rst = 1'b0;
        #1 check_all("reset0");
        cycle("reset_hold", 1'b1, 1'b1);
        cycle("reset_hold", 1'b1, 1'b1);
        rst = 1'b1;
        clear_obs();
        for (int i = 0; i < 12; i++) cycle("latency", 1'b1, 1'b1);
        check_int("latency.first_rise_cyc", first_rise_cyc, SYNC + 1 + DT);
        check_int("latency.rise_count", rise_seen, 1);
        check("latency.level_held", o_level, 1'b1);

        // Bounce rejection from a clean low level.
        async_reset("bounce_rst");
        for (int i = 0; i < 6; i++) cycle("bounce_pre", 1'b0, 1'b1);
        clear_obs();
        for (int i = 0; i < 8; i++) cycle("bounce", ((i / 2) % 2) == 0, 1'b1);
        for (int i = 0; i < 10; i++) cycle("bounce_post", 1'b0, 1'b1);
        check_int("bounce.rise_count", rise_seen, 0);
        check("bounce.busy_seen", busy_seen > 0, 1'b1);
        check("bounce.level", o_level, 1'b0);

        // Sparse ticks: one tick every 10 clk.
        clear_obs();
        for (int i = 0; i < 80; i++) cycle("sparse", 1'b1, (i % 10) == 9);
        check_int("sparse.rise_count", rise_seen, 1);

        // Bounce on the same edge as the qualifying tick.
        async_reset("simul_rst");
        for (int i = 0; i < 4; i++) cycle("simul_pre", 1'b0, 1'b1);
        clear_obs();
        for (int i = 0; i < 4; i++) cycle("simul_hi", 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cycle("simul_lo", 1'b0, 1'b1);
        check_int("simul.rise_count", rise_seen, 0);
        check("simul.busy_after", o_busy, 1'b0);

        // Reset while qualifying a falling edge from level 1.
        for (int i = 0; i < 12; i++) cycle("midrst_hi", 1'b1, 1'b1);
        check("midrst.level_before", o_level, 1'b1);
        for (int i = 0; i < 4; i++) cycle("midrst_lo", 1'b0, 1'b1);
        check("midrst.busy_before", o_busy, 1'b1);
        clear_obs();
        async_reset("midrst");
        for (int i = 0; i < 15; i++) cycle("midrst_post", 1'b0, 1'b1);
        check_int("midrst.fall_count", fall_seen, 0);

        // Long press, then release and press again.
        for (int p = 0; p < 2; p++) begin
            clear_obs();
            for (int i = 0; i < 30; i++) cycle("long_press", 1'b1, 1'b1);
`ifdef SW_DEBOUNCE_LONGPRESS_EN
            check_int("long.count", long_seen, 1);
            check_int("long.delay", last_long_cyc - last_rise_cyc, LONG);
`else
            check_int("long.count", long_seen, 0);
`endif
            for (int i = 0; i < 12; i++) cycle("long_release", 1'b0, 1'b1);
        end

        // Randomized activity with varied tick density and occasional reset.
        for (int seg = 0; seg < 150; seg++) begin
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 14);
            tp  = $urandom_range(1, 4);
            if ($urandom_range(0, 29) == 0) async_reset("rand_rst");
            for (int i = 0; i < len; i++)
                cycle("rand", v, $urandom_range(0, tp - 1) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
